// File: rtl/johnson_code_checker_pkg.sv
// Shared definitions for the Johnson code receive checker.
package johnson_code_checker_pkg;

  // Checker FSM encoding; the fourth code is never entered and falls back to acquisition.
  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'd0,
    ST_LOCKED  = 2'd1,
    ST_FAULT   = 2'd2,
    ST_UNUSED  = 2'd3
  } state_e;

endpackage

// File: rtl/johnson_code_checker_sync_2ff.sv
// Two-flop synchronizer bringing the externally clocked Johnson code into in_clk.
module johnson_code_checker_sync_2ff #(
  parameter int W = 3
) (
  input  logic         in_clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Metastability filter: first flop may go metastable, second hands a settled value on.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/johnson_code_checker.sv
// Receive-side Johnson code checker: validates sampled codes and their step order,
// converts them to a binary phase index and counts completed revolutions.
module johnson_code_checker
  import johnson_code_checker_pkg::*;
#(
  parameter int N      = 3,
  parameter int WRAP_W = 8,
  localparam int IW    = $clog2(2 * N)
) (
  input  logic              in_clk,
  input  logic              rst,
  input  logic [N-1:0]      johnson_in,
  input  logic              sample_en,
  input  logic              fault_clr,
  output logic [IW-1:0]     index,
  output logic              valid,
  output logic              step,
  output logic              err_code,
  output logic              err_seq,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [1:0]        state
);

  localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

  // A Johnson code read MSB to LSB changes value at most once (a run of ones then
  // zeros, or zeros then ones); any second transition marks a corrupted code.
  function automatic logic is_legal(input logic [N-1:0] code);
    int changes;
    changes = 0;
    for (int b = 0; b < N - 1; b++) begin
      if (code[b] != code[b+1]) changes++;
    end
    return (changes <= 1);
  endfunction

  // Filling phase (MSB set or all-zero) counts ones directly; emptying phase
  // counts down from 2N as the ones drain out of the top.
  function automatic logic [IW-1:0] code2idx(input logic [N-1:0] code);
    int ones;
    ones = 0;
    for (int b = 0; b < N; b++) begin
      if (code[b]) ones++;
    end
    if (code[N-1] || (code == '0)) return IW'(ones);
    return IW'(2 * N - ones);
  endfunction

  logic [N-1:0]      code_s;
  logic              legal_w;
  logic [IW-1:0]     dec_w;
  logic [IW-1:0]     idx_next_w;

  state_e            state_q, state_d;
  logic [IW-1:0]     index_q, index_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic              valid_q, valid_d;
  logic              step_q, step_d;
  logic              err_code_q, err_code_d;
  logic              err_seq_q, err_seq_d;

  johnson_code_checker_sync_2ff #(
    .W(N)
  ) u_sync (
    .in_clk (in_clk),
    .rst    (rst),
    .d      (johnson_in),
    .q      (code_s)
  );

  assign legal_w    = is_legal(code_s);
  assign dec_w      = code2idx(code_s);
  assign idx_next_w = (index_q == LAST_IDX) ? '0 : index_q + IW'(1);

  // State register.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) state_q <= ST_ACQUIRE;
    else      state_q <= state_d;
  end

  // Next-state logic; fault_clr has priority over any sample taken while faulted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACQUIRE: begin
        if (sample_en && legal_w) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (sample_en) begin
          if (!legal_w)                                   state_d = ST_FAULT;
          else if ((dec_w != index_q) && (dec_w != idx_next_w)) state_d = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (fault_clr) state_d = ST_ACQUIRE;
      end
      default: state_d = ST_ACQUIRE;
    endcase
  end

  // Output/datapath next values; at most one pulse is raised per sample.
  always_comb begin
    index_d    = index_q;
    wrap_d     = wrap_q;
    valid_d    = (state_d == ST_LOCKED);
    step_d     = 1'b0;
    err_code_d = 1'b0;
    err_seq_d  = 1'b0;
    case (state_q)
      ST_ACQUIRE: begin
        if (sample_en) begin
          if (legal_w) index_d    = dec_w;
          else         err_code_d = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (sample_en) begin
          if (!legal_w) begin
            err_code_d = 1'b1;
          end else if (dec_w == index_q) begin
            // Source stalled: hold silently.
          end else if (dec_w == idx_next_w) begin
            index_d = dec_w;
            step_d  = 1'b1;
            if (index_q == LAST_IDX) wrap_d = wrap_q + WRAP_W'(1);
          end else begin
            err_seq_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs so nothing reaches the pins combinationally.
  always_ff @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      index_q    <= '0;
      wrap_q     <= '0;
      valid_q    <= 1'b0;
      step_q     <= 1'b0;
      err_code_q <= 1'b0;
      err_seq_q  <= 1'b0;
    end else begin
      index_q    <= index_d;
      wrap_q     <= wrap_d;
      valid_q    <= valid_d;
      step_q     <= step_d;
      err_code_q <= err_code_d;
      err_seq_q  <= err_seq_d;
    end
  end

  assign index    = index_q;
  assign wrap_cnt = wrap_q;
  assign valid    = valid_q;
  assign step     = step_q;
  assign err_code = err_code_q;
  assign err_seq  = err_seq_q;
  assign state    = state_q;

endmodule

// File: tb/tb_johnson_code_checker.sv
// Bench for johnson_code_checker (N=3, WRAP_W=8): directed code sequences checked
// every cycle against a behavioural model, plus literal expectations per scenario.
module tb_johnson_code_checker;

  logic       in_clk;
  logic       rst;
  logic [2:0] johnson_in;
  logic       sample_en;
  logic       fault_clr;
  logic [2:0] index;
  logic       valid;
  logic       step;
  logic       err_code;
  logic       err_seq;
  logic [7:0] wrap_cnt;
  logic [1:0] state;

  johnson_code_checker #(.N(3), .WRAP_W(8)) dut (
    .in_clk     (in_clk),
    .rst        (rst),
    .johnson_in (johnson_in),
    .sample_en  (sample_en),
    .fault_clr  (fault_clr),
    .index      (index),
    .valid      (valid),
    .step       (step),
    .err_code   (err_code),
    .err_seq    (err_seq),
    .wrap_cnt   (wrap_cnt),
    .state      (state)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int cnt_step = 0;
  int cnt_ec = 0;
  int cnt_es = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Legal codes generated by walking the Johnson counter itself: shift right, inverted LSB into MSB.
  function automatic int jdec(input logic [2:0] c);
    logic [2:0] g;
    g = 3'b000;
    for (int k = 0; k < 6; k++) begin
      if (g == c) return k;
      g = {~g[0], g[2:1]};
    end
    return -1;
  endfunction

  // Behavioural model: two-sample delay of the pin, then the phase-tracking rules.
  logic [2:0] m_s1, m_s2;
  int  m_mode;   // 0 acquire, 1 locked, 2 fault
  int  m_idx;
  int  m_wrap;
  bit  e_step, e_ec, e_es;

  always @(posedge in_clk or negedge rst) begin
    if (!rst) begin
      m_s1 <= 3'b000; m_s2 <= 3'b000;
      m_mode <= 0; m_idx <= 0; m_wrap <= 0;
      e_step <= 1'b0; e_ec <= 1'b0; e_es <= 1'b0;
    end else begin
      m_s1 <= johnson_in;
      m_s2 <= m_s1;
      e_step <= 1'b0; e_ec <= 1'b0; e_es <= 1'b0;
      if (m_mode == 0) begin
        if (sample_en) begin
          if (jdec(m_s2) >= 0) begin m_mode <= 1; m_idx <= jdec(m_s2); end
          else e_ec <= 1'b1;
        end
      end else if (m_mode == 1) begin
        if (sample_en) begin
          if (jdec(m_s2) < 0) begin
            m_mode <= 2; e_ec <= 1'b1;
          end else if (jdec(m_s2) == m_idx) begin
            m_mode <= 1;
          end else if (jdec(m_s2) == (m_idx + 1) % 6) begin
            m_idx <= jdec(m_s2); e_step <= 1'b1;
            if (m_idx == 5) m_wrap <= (m_wrap + 1) % 256;
          end else begin
            m_mode <= 2; e_es <= 1'b1;
          end
        end
      end else begin
        if (fault_clr) m_mode <= 0;
      end
    end
  end

  // Compare process: every output against the model, mid-cycle.
  initial forever begin
    @(negedge in_clk);
    if (chk_en) begin
      check("index", 32'(index), 32'(m_idx));
      check("valid", 32'(valid), 32'(m_mode == 1));
      check("step", 32'(step), 32'(e_step));
      check("err_code", 32'(err_code), 32'(e_ec));
      check("err_seq", 32'(err_seq), 32'(e_es));
      check("wrap_cnt", 32'(wrap_cnt), 32'(m_wrap));
      check("state", 32'(state), 32'(m_mode));
      check("pulse_onehot", 32'(32'(step) + 32'(err_code) + 32'(err_seq) <= 1), 32'd1);
      if (step) cnt_step++;
      if (err_code) cnt_ec++;
      if (err_seq) cnt_es++;
    end
  end

  // Present a code, let it cross the synchronizer, then give one sample tick.
  task automatic samp(input logic [2:0] c, input logic clr);
    johnson_in = c;
    repeat (3) @(posedge in_clk);
    #1;
    sample_en = 1'b1;
    fault_clr = clr;
    @(posedge in_clk);
    #1;
    sample_en = 1'b0;
    fault_clr = 1'b0;
    @(posedge in_clk);
    #1;
  endtask

  logic [2:0] seq [7];
  int         eidx [7];
  int s_step, s_ec, s_es;

  initial begin
    seq  = '{3'b000, 3'b100, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
    eidx = '{0, 1, 2, 3, 4, 5, 0};
    rst = 1'b0; johnson_in = 3'b000; sample_en = 1'b0; fault_clr = 1'b0;
    repeat (3) @(posedge in_clk);
    #1;
    rst = 1'b1;
    chk_en = 1'b1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);

    // Illegal code while acquiring: error pulse, no lock.
    samp(3'b010, 1'b0);
    check("acq_illegal_ec", 32'(cnt_ec), 32'd1);
    check("acq_illegal_state", 32'(state), 32'd0);

    // Lock and count a full revolution.
    s_step = cnt_step;
    for (int i = 0; i < 7; i++) begin
      samp(seq[i], 1'b0);
      check("lock_index", 32'(index), 32'(eidx[i]));
      check("lock_valid", 32'(valid), 32'd1);
    end
    check("lock_steps", 32'(cnt_step - s_step), 32'd6);
    check("lock_wrap", 32'(wrap_cnt), 32'd1);

    // Stall: same code repeated while locked.
    samp(3'b100, 1'b0);
    samp(3'b110, 1'b0);
    s_step = cnt_step; s_ec = cnt_ec; s_es = cnt_es;
    for (int i = 0; i < 4; i++) samp(3'b110, 1'b0);
    check("stall_index", 32'(index), 32'd2);
    check("stall_pulses", 32'(cnt_step - s_step + cnt_ec - s_ec + cnt_es - s_es), 32'd0);

    // Illegal code while locked.
    samp(3'b111, 1'b0);
    s_ec = cnt_ec;
    samp(3'b101, 1'b0);
    check("illegal_ec", 32'(cnt_ec - s_ec), 32'd1);
    check("illegal_state", 32'(state), 32'd2);
    check("illegal_valid", 32'(valid), 32'd0);
    check("illegal_index", 32'(index), 32'd3);

    // Samples ignored in FAULT, then clear and relock at 100.
    samp(3'b110, 1'b0);
    check("fault_ignore", 32'(state), 32'd2);
    johnson_in = 3'b100;
    @(posedge in_clk); #1; fault_clr = 1'b1;
    @(posedge in_clk); #1; fault_clr = 1'b0;
    check("clr_state", 32'(state), 32'd0);
    samp(3'b100, 1'b0);
    check("relock_index", 32'(index), 32'd1);

    // Skip forward: sequence error.
    s_es = cnt_es;
    samp(3'b111, 1'b0);
    check("seq_es", 32'(cnt_es - s_es), 32'd1);
    check("seq_state", 32'(state), 32'd2);
    check("seq_index", 32'(index), 32'd1);
    // fault_clr with sample_en: clear wins, no lock this cycle.
    samp(3'b111, 1'b1);
    check("clr_wins_state", 32'(state), 32'd0);
    check("clr_wins_valid", 32'(valid), 32'd0);
    samp(3'b111, 1'b0);
    check("relock3_index", 32'(index), 32'd3);
    check("relock3_state", 32'(state), 32'd1);
    // fault_clr outside FAULT has no effect.
    samp(3'b111, 1'b1);
    check("clr_locked", 32'(state), 32'd1);

    // Asynchronous reset mid-cycle, with wrap_cnt and valid nonzero beforehand.
    samp(3'b011, 1'b0);
    samp(3'b001, 1'b0);
    samp(3'b000, 1'b0);
    check("pre_rst_wrap", 32'(wrap_cnt), 32'd2);
    @(posedge in_clk); #3;
    rst = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_index", 32'(index), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_wrap", 32'(wrap_cnt), 32'd0);
    check("arst_pulses", 32'({step, err_code, err_seq}), 32'd0);
    repeat (2) @(posedge in_clk);
    #1;
    rst = 1'b1;

    // 256 revolutions: wrap counter rolls back to 0.
    samp(3'b000, 1'b0);
    s_step = cnt_step; s_ec = cnt_ec; s_es = cnt_es;
    for (int r = 0; r < 256; r++) begin
      for (int k = 1; k < 7; k++) samp(seq[k], 1'b0);
      if (r == 254) check("wrap_255", 32'(wrap_cnt), 32'd255);
    end
    check("wrap_roll", 32'(wrap_cnt), 32'd0);
    check("wrap_steps", 32'(cnt_step - s_step), 32'd1536);
    check("wrap_noerr", 32'(cnt_ec - s_ec + cnt_es - s_es), 32'd0);
    check("wrap_valid", 32'(valid), 32'd1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
